row_push_up: RTL and testbench
==============================

ROW_PUSH_UP -- requirements
Module: row_push_up

Interface
REQ-001 SHALL have parameter BOARD_W, default 10, board width in blocks.
REQ-002 SHALL have parameter BOARD_H, default 25, board height in rows (row 0 = top).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to push the board up one row and insert a garbage row at the bottom.
REQ-006 SHALL have port hole_x  input  4  column left empty in the garbage row; latched at start.
REQ-007 SHALL have port fill_color  input  6  block code for non-hole cells of the garbage row; latched at start.
REQ-008 SHALL have port ram_Q  input  6  board RAM read data.
REQ-009 SHALL have port ram_addr  output  8  board RAM address, registered; addr = y*BOARD_W + x.
REQ-010 SHALL have port ram_data  output  6  board RAM write data, registered.
REQ-011 SHALL have port ram_wren  output  1  board RAM write enable, registered.
REQ-012 SHALL have port busy  output  1  high while an operation is in progress.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port overflow  output  1  valid with done; high if row 0 held any non-zero block before the push.

Function
REQ-015 SHALL treat the board RAM as synchronous with one-cycle read latency: ram_Q reflects the address registered on the previous edge.
REQ-016 SHALL implement states IDLE, SCAN, COPY_RD, COPY_WAIT, COPY_WR, FILL, DONE.
REQ-017 SHALL, in IDLE with start high, latch hole_x/fill_color, set busy, clear overflow, enter SCAN; start outside IDLE SHALL be ignored.
REQ-018 SCAN SHALL read addresses 0..BOARD_W-1 at 2 cycles per cell, setting overflow if any ram_Q != 0; no writes.
REQ-019 COPY SHALL, for a = BOARD_W .. BOARD_W*BOARD_H-1 ascending: COPY_RD presents a (wren 0), COPY_WAIT idles, COPY_WR presents a-BOARD_W with ram_data = ram_Q and wren 1.
REQ-020 Ascending order SHALL guarantee every source cell is read before it is overwritten.
REQ-021 FILL SHALL write addresses (BOARD_H-1)*BOARD_W + x, x = 0..BOARD_W-1, one per cycle, data 0 when x == latched hole_x, else latched fill_color.
REQ-022 hole_x >= BOARD_W SHALL produce a row with no hole (all fill_color).
REQ-023 fill_color == 0 SHALL insert an all-empty row (pure scroll-up).
REQ-024 DONE SHALL last one cycle: done 1, wren 0, busy 0 on the following cycle, return to IDLE.
REQ-025 overflow SHALL NOT abort the operation; row 0 contents are discarded and overflow holds until the next accepted start.
REQ-026 ram_wren SHALL be high only in COPY_WR and FILL cycles.
REQ-027 Latency start-edge to done-high SHALL be 2*W + 3*W*(H-1) + W + 1 cycles (751 at defaults).
REQ-028 Address arithmetic SHALL be 8-bit unsigned; BOARD_W*BOARD_H SHALL be <= 256.

Reset
REQ-029 resetn low SHALL immediately force state IDLE, ram_addr 0, ram_data 0, ram_wren 0, busy 0, done 0, overflow 0, latched inputs 0.
REQ-030 Reset mid-operation SHALL leave RAM partially shifted; no restore is required.
REQ-031 After resetn rises, first start SHALL be accepted on the first edge with start high.

Verification
REQ-032 Board rows 0..23 empty, row 24 all 6'd3; start, hole_x=4, fill_color=6'd7 -> row 23 all 3, row 24 = 7 except x=4 = 0, overflow 0, done at cycle 751.
REQ-033 Row 0 x=2 = 6'd5, start -> done with overflow 1; row 0 equals prior row 1; rows shifted correctly.
REQ-034 Start with hole_x=15, fill_color=6'd1 -> row 24 all 1; start with fill_color=0 -> row 24 all 0.
REQ-035 Start pulses during busy -> ignored; exactly one done pulse; latched hole_x unchanged.
REQ-036 resetn low at cycle 300 of an operation -> wren 0 same cycle, busy 0, done never pulses; next start runs full 751-cycle sequence.
REQ-037 Monitor: no write to address a before a read of a in the same operation; wren never high outside COPY_WR/FILL.

Source files
------------

// File: rtl/row_push_up.sv
// rtl/row_push_up.sv - scrolls a board held in synchronous RAM up one row and inserts a garbage row
//
// Purpose: on a start request, scans row 0 for occupied cells (overflow), moves every
// row up by one (row y+1 -> row y), then writes a garbage row into the bottom row with
// a single hole column.
//
// Ports:
//   clk        - single clock, all state changes on the rising edge
//   resetn     - asynchronous, active-low reset
//   start      - one-cycle request, honoured only while idle
//   hole_x     - column left empty in the garbage row (latched at start)
//   fill_color - block code for the non-hole garbage cells (latched at start)
//   ram_Q      - board RAM read data, one cycle after the address edge
//   ram_addr   - board RAM address (y*BOARD_W + x), registered
//   ram_data   - board RAM write data, registered
//   ram_wren   - board RAM write enable, registered
//   busy       - operation in progress
//   done       - one-cycle completion pulse
//   overflow   - row 0 held a non-zero block before the push; valid with done

module row_push_up #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 25
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [3:0] hole_x,
  input  logic [5:0] fill_color,
  input  logic [5:0] ram_Q,
  output logic [7:0] ram_addr,
  output logic [5:0] ram_data,
  output logic       ram_wren,
  output logic       busy,
  output logic       done,
  output logic       overflow
);

  localparam logic [7:0] W8        = 8'(BOARD_W);
  localparam logic [7:0] W_LAST    = 8'(BOARD_W - 1);
  localparam logic [7:0] LAST_CELL = 8'(BOARD_W * BOARD_H - 1);
  localparam logic [7:0] ROW_LAST  = 8'((BOARD_H - 1) * BOARD_W);

  typedef enum logic [2:0] {
    IDLE, SCAN, COPY_RD, COPY_WAIT, COPY_WR, FILL, DONE
  } state_t;

  state_t     state, state_nx;

  // idx is the scan column, the copy source address, or the fill column
  logic [7:0] idx, idx_nx;
  logic       phase, phase_nx;
  logic [3:0] hole_q, hole_nx;
  logic [5:0] color_q, color_nx;

  logic [7:0] addr_nx;
  logic [5:0] data_nx;
  logic       wren_nx, busy_nx, done_nx, ovf_nx;

  logic [7:0] idx_inc;
  logic [5:0] fill_first;
  logic [5:0] fill_next;

  assign idx_inc = idx + 8'd1;

  // A hole_x beyond the board width never matches a column, giving a solid row
  assign fill_first = (hole_q == 4'd0) ? 6'd0 : color_q;
  assign fill_next  = (idx_inc == {4'd0, hole_q}) ? 6'd0 : color_q;

  // State and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      idx      <= 8'd0;
      phase    <= 1'b0;
      hole_q   <= 4'd0;
      color_q  <= 6'd0;
      ram_addr <= 8'd0;
      ram_data <= 6'd0;
      ram_wren <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      phase    <= phase_nx;
      hole_q   <= hole_nx;
      color_q  <= color_nx;
      ram_addr <= addr_nx;
      ram_data <= data_nx;
      ram_wren <= wren_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      overflow <= ovf_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (start) state_nx = SCAN;
      SCAN:      if (phase && idx == W_LAST) state_nx = COPY_RD;
      COPY_RD:   state_nx = COPY_WAIT;
      COPY_WAIT: state_nx = COPY_WR;
      COPY_WR:   state_nx = (idx == LAST_CELL) ? FILL : COPY_RD;
      FILL:      if (idx == W_LAST) state_nx = DONE;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Output / datapath logic: computes the values registered on the next edge,
  // so every RAM control appears in the same cycle as the state that owns it.
  always_comb begin
    idx_nx   = idx;
    phase_nx = phase;
    hole_nx  = hole_q;
    color_nx = color_q;
    addr_nx  = ram_addr;
    data_nx  = ram_data;
    wren_nx  = 1'b0;
    busy_nx  = busy;
    done_nx  = 1'b0;
    ovf_nx   = overflow;
    case (state)
      IDLE: begin
        if (start) begin
          hole_nx  = hole_x;
          color_nx = fill_color;
          idx_nx   = 8'd0;
          phase_nx = 1'b0;
          addr_nx  = 8'd0;
          data_nx  = 6'd0;
          busy_nx  = 1'b1;
          ovf_nx   = 1'b0;
        end
      end
      SCAN: begin
        if (!phase) begin
          // address is being registered into the RAM this cycle
          phase_nx = 1'b1;
        end else begin
          if (ram_Q != 6'd0) ovf_nx = 1'b1;
          phase_nx = 1'b0;
          if (idx == W_LAST) begin
            idx_nx  = W8;
            addr_nx = W8;
          end else begin
            idx_nx  = idx_inc;
            addr_nx = idx_inc;
          end
        end
      end
      COPY_RD: begin
      end
      COPY_WAIT: begin
        // ram_Q now holds the source cell; write it one row higher
        addr_nx = idx - W8;
        data_nx = ram_Q;
        wren_nx = 1'b1;
      end
      COPY_WR: begin
        if (idx == LAST_CELL) begin
          idx_nx  = 8'd0;
          addr_nx = ROW_LAST;
          data_nx = fill_first;
          wren_nx = 1'b1;
        end else begin
          idx_nx  = idx_inc;
          addr_nx = idx_inc;
        end
      end
      FILL: begin
        if (idx == W_LAST) begin
          done_nx = 1'b1;
        end else begin
          idx_nx  = idx_inc;
          addr_nx = ram_addr + 8'd1;
          data_nx = fill_next;
          wren_nx = 1'b1;
        end
      end
      DONE: begin
        busy_nx = 1'b0;
      end
      default: begin
        busy_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_row_push_up.sv
// tb/tb_row_push_up.sv - self-checking bench for row_push_up with a RAM model and write scoreboard
module tb_row_push_up;

  localparam int W        = 10;
  localparam int H        = 25;
  localparam int CELLS    = W * H;
  localparam int ROW_LAST = (H - 1) * W;
  localparam int LATENCY  = 2 * W + 3 * W * (H - 1) + W + 1;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [3:0] hole_x;
  logic [5:0] fill_color;
  logic [5:0] ram_Q;
  logic [7:0] ram_addr;
  logic [5:0] ram_data;
  logic       ram_wren;
  logic       busy;
  logic       done;
  logic       overflow;

  row_push_up #(.BOARD_W(W), .BOARD_H(H)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .hole_x     (hole_x),
    .fill_color (fill_color),
    .ram_Q      (ram_Q),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_wren   (ram_wren),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Synchronous board RAM, one-cycle read latency, with a bulk preload port
  logic [5:0] mem      [0:255];
  logic [5:0] init_mem [0:255];
  logic       load = 1'b0;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
    end else if (ram_wren) begin
      mem[ram_addr] <= ram_data;
    end
    ram_Q <= mem[ram_addr];
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [5:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [5:0] exp_board [0:255];
  logic       exp_ovf;
  int         op_id = 0;
  int         read_op [0:255];

  // Write monitor: pops the scoreboard and checks read-before-write per operation
  always @(negedge clk) begin
    wr_t e;
    if (resetn && busy && !ram_wren) read_op[ram_addr] = op_id;
    if (ram_wren) begin
      check("wr_while_busy", busy, 1);
      check($sformatf("wr_after_rd_a%0d", ram_addr), read_op[ram_addr], op_id);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL wr_unexpected observed=addr %0d expected=no write", ram_addr);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", ram_addr, e.addr);
        check("wr_data", ram_data, e.data);
      end
    end
  end

  // Builds the expected board and write sequence from the current RAM contents
  task automatic prepare(input logic [3:0] h, input logic [5:0] f);
    logic [5:0] old [0:255];
    wr_t w;
    for (int i = 0; i < 256; i++) old[i] = mem[i];
    exp_ovf = 1'b0;
    for (int x = 0; x < W; x++) if (old[x] != 6'd0) exp_ovf = 1'b1;
    for (int a = 0; a < CELLS; a++)
      exp_board[a] = (a < ROW_LAST) ? old[a + W] : (((a - ROW_LAST) == int'(h)) ? 6'd0 : f);
    for (int a = W; a < CELLS; a++) begin
      w.addr = 8'(a - W);
      w.data = old[a];
      exp_q.push_back(w);
    end
    for (int x = 0; x < W; x++) begin
      w.addr = 8'(ROW_LAST + x);
      w.data = (x == int'(h)) ? 6'd0 : f;
      exp_q.push_back(w);
    end
    op_id++;
  endtask

  task automatic load_board();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
  endtask

  // Cycle 1 is the cycle right after the edge that accepts start
  task automatic run_op(input string tag, input logic [3:0] h, input logic [5:0] f, input bit poke);
    int cyc;
    int dones;
    prepare(h, f);
    hole_x     = h;
    fill_color = f;
    start      = 1'b1;
    cyc   = 0;
    dones = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (done) dones++;
      start = 1'b0;
      if (poke && (cyc == 5 || cyc == 400)) begin
        start      = 1'b1;
        hole_x     = h + 4'd1;
        fill_color = f ^ 6'h3f;
      end
    end while (!done && cyc < 2000);
    check({tag, "_latency"}, cyc, LATENCY);
    check({tag, "_busy_at_done"}, busy, 1);
    check({tag, "_overflow"}, overflow, exp_ovf);
    if (poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (done) dones++;
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_busy_after"}, busy, 0);
    repeat (20) begin
      @(negedge clk);
      if (done) dones++;
    end
    check({tag, "_done_pulses"}, dones, 1);
    check({tag, "_overflow_held"}, overflow, exp_ovf);
    check({tag, "_writes_left"}, exp_q.size(), 0);
    for (int i = 0; i < CELLS; i++)
      check($sformatf("%s_cell%0d", tag, i), mem[i], exp_board[i]);
  endtask

  initial begin
    int cyc;
    int dones;
    resetn     = 1'b0;
    start      = 1'b0;
    hole_x     = 4'd0;
    fill_color = 6'd0;
    for (int i = 0; i < 256; i++) read_op[i] = 0;
    repeat (3) @(negedge clk);
    check("rst_addr", ram_addr, 0);
    check("rst_data", ram_data, 0);
    check("rst_wren", ram_wren, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);

    // Empty board with a solid bottom row of 3
    for (int i = 0; i < 256; i++) init_mem[i] = (i >= ROW_LAST && i < CELLS) ? 6'd3 : 6'd0;
    load_board();
    resetn = 1'b1;
    @(negedge clk);
    run_op("basic", 4'd4, 6'd7, 1'b0);

    // Row 0 occupied at x=2, random contents elsewhere
    for (int i = 0; i < 256; i++) init_mem[i] = (i >= W) ? 6'($urandom_range(63, 0)) : 6'd0;
    init_mem[2] = 6'd5;
    load_board();
    run_op("ovf", 4'd9, 6'd12, 1'b0);

    // Hole out of range, then a pure scroll with empty fill
    run_op("nohole", 4'd15, 6'd1, 1'b0);
    run_op("empty", 4'd5, 6'd0, 1'b0);

    // Start pulses while busy (and during the done cycle) must be ignored
    for (int i = 0; i < 256; i++) init_mem[i] = 6'($urandom_range(63, 0));
    load_board();
    run_op("ignore", 4'd3, 6'd9, 1'b0);
    run_op("poke", 4'd3, 6'd9, 1'b1);

    // Reset in the middle of an operation
    prepare(4'd2, 6'd4);
    hole_x     = 4'd2;
    fill_color = 6'd4;
    start      = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end while (cyc < 300);
    resetn = 1'b0;
    #1;
    check("midrst_wren", ram_wren, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_addr", ram_addr, 0);
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);
    check("midrst_idle", busy, 0);
    run_op("after_rst", 4'd0, 6'd63, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
